// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants and FSM state type for seq_alu
// Contents:
//   OP_ADD..OP_MUL : 3-bit opcode encodings
//   state_t        : control FSM states (IDLE, MUL)
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one bit per cycle
// Ports:
//   clk, rst       : clock, synchronous active-high reset (aborts a running multiply)
//   start          : latch a/b and begin; ignored while busy
//   a, b           : N-bit unsigned operands
//   busy           : iteration in progress
//   done           : high during the final iteration (counter == N-1)
//   product        : 2N-bit product, valid while done is high
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0]  r_count;
  logic           r_busy;
  logic [N-1:0]   r_mcand;
  // Upper half accumulates partial sums; lower half holds the multiplier,
  // consumed LSB-first as the whole register shifts right each iteration.
  logic [2*N-1:0] r_acc;

  logic [N:0]     w_sum;
  logic [2*N-1:0] w_acc_next;

  assign w_sum      = {1'b0, r_acc[2*N-1:N]} + {1'b0, (r_acc[0] ? r_mcand : {N{1'b0}})};
  assign w_acc_next = {w_sum, r_acc[N-1:1]};

  assign busy    = r_busy;
  assign done    = r_busy && (r_count == CW'(N - 1));
  // The top captures the product on the done edge, so expose the
  // post-iteration value rather than waiting another cycle.
  assign product = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (start && !r_busy) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_mcand <= a;
      r_acc   <= {{N{1'b0}}, b};
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      if (done) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - N-bit registered ALU with valid/ready handshakes and sequential MUL
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : operation handshake (a, b, control)
//   a, b, control             : operands and 3-bit opcode
//   out_valid/out_ready       : result handshake
//   out, out_hi               : result (out_hi = high half of MUL product, else 0)
//   carry, overflow, zero, negative : flags registered with out
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  localparam int LOG2N = $clog2(N);

  state_t         r_state;
  state_t         w_state_next;

  logic           r_out_valid;
  logic [N-1:0]   r_out;
  logic [N-1:0]   r_out_hi;
  logic           r_carry;
  logic           r_ovf;
  logic           r_zero;
  logic           r_neg;

  logic           w_accept;
  logic           w_start;
  logic           w_wr_alu;
  logic           w_mul_busy;
  logic           w_mul_done;
  logic [2*N-1:0] w_product;

  logic [N:0]     w_add;
  logic [N:0]     w_sub;
  logic [N:0]     w_shl;
  logic           w_slt;
  logic [N-1:0]   w_res;
  logic           w_c;
  logic           w_v;

  assign in_ready = !rst && (r_state == IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && (control == OP_MUL);
  assign w_wr_alu = w_accept && (control != OP_MUL);

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .a       (a),
    .b       (b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  // Bit N of the widened shift is the last bit pushed out; 0 for shift 0.
  assign w_shl = {1'b0, a} << b[LOG2N-1:0];
  // Differing signs decide directly; equal signs cannot overflow the subtract.
  assign w_slt = (a[N-1] != b[N-1]) ? a[N-1] : w_sub[N-1];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (control)
      OP_ADD: begin
        w_res = w_add[N-1:0];
        w_c   = w_add[N];
        w_v   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
      end
      OP_SUB: begin
        w_res = w_sub[N-1:0];
        w_c   = w_sub[N];
        w_v   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(N-1){1'b0}}, w_slt};
      OP_SHL: begin
        w_res = w_shl[N-1:0];
        w_c   = w_shl[N];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      if (w_wr_alu) begin
        r_out    <= w_res;
        r_out_hi <= '0;
        r_carry  <= w_c;
        r_ovf    <= w_v;
        r_zero   <= (w_res == '0);
        r_neg    <= w_res[N-1];
      end else if (w_mul_done) begin
        r_out    <= w_product[N-1:0];
        r_out_hi <= w_product[2*N-1:N];
        r_carry  <= 1'b0;
        r_ovf    <= |w_product[2*N-1:N];
        r_zero   <= (w_product == '0);
        r_neg    <= w_product[N-1];
      end

      // A MUL accept implies the old result was free or consumed this edge.
      if (w_wr_alu || w_mul_done) begin
        r_out_valid <= 1'b1;
      end else if (w_start || out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_start)    w_state_next = MUL;
      MUL:  if (w_mul_done) w_state_next = IDLE;
    endcase
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_hi    = r_out_hi;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised N-bit ALU with valid/ready handshakes on input and output, registered results, and a full flag set (carry, overflow, zero, negative). It adds a multi-cycle shift-add multiplier with a 2N-bit product. It is the next-generation replacement for the 4-bit combinational ALU and sits between operand sources and a result consumer that may apply backpressure.

## Interface
- N, 8: operand/result width (N ≥ 2, power of two)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a, b  input  N  operands
- control  input  3  opcode
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer accepts result this cycle
- out  output  N  result (low half for MUL)
- out_hi  output  N  high half of MUL product; 0 for all other ops
- carry, overflow, zero, negative  output  1 each  result flags, registered with out

## Operation
- Opcodes:
  - 000 ADD: carry = carry-out; overflow = signed overflow.
  - 001 SUB (a−b): carry = borrow (a<b unsigned); overflow = signed overflow.
  - 010 AND, 011 OR, 100 XOR: carry = overflow = 0.
  - 101 SLT: out = 1 if signed a<b, else 0; carry = overflow = 0.
  - 110 SHL: out = a << b[log2N−1:0]; carry = last bit shifted out (0 when shift amount is 0); overflow = 0.
  - 111 MUL: unsigned; {out_hi,out} = a*b; overflow = (out_hi≠0); carry = 0.
- zero = (out==0) for all ops, except MUL, where zero = ({out_hi,out}==0). negative = out[N−1].
- Accept condition: in_valid && in_ready.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready).
- Result registers (out, out_hi, flags) change only when a new result is written. They stay stable while out_valid && !out_ready.
- out_valid is set when a result is written. It is cleared on out_ready, unless a new result is written on the same edge.
- FSM states IDLE and MUL:
  - IDLE, non-MUL accept: result written on the same edge; stay in IDLE.
  - IDLE, MUL accept: latch a and b; clear accumulator and counter; go to MUL. out_valid clears on this edge (the output was free or being consumed).
  - MUL: one shift-add iteration per cycle; counter 0..N−1. On the iteration with counter==N−1, write the product and flags, set out_valid, and return to IDLE. in_ready = 0 throughout MUL.
- Reset:
  - state = IDLE, out_valid = 0, out = out_hi = 0, all flags 0, counter = 0.
  - Reset during MUL aborts the operation; no result is produced.

## Timing
- Non-MUL: accept at edge k → out_valid and result visible after edge k (latency 1).
- Back-to-back non-MUL ops at one per cycle when out_ready = 1.
- MUL: accept at edge k → result after edge k+N (latency N+1 cycles to out_valid). Throughput is one MUL per N+1 cycles.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready = 0. When out_ready rises, a waiting op is accepted on that same edge.
- in_ready and out_valid are 0 in the first cycle after reset deasserts only for out_valid; in_ready = 1 in that cycle.

## Structure
- Shared package alu_pkg:
  - Opcode constants OP_ADD…OP_MUL.
  - FSM state type {IDLE, MUL}.
- Sub-module alu_mul_seq: iterative shift-add multiplier.
  - Ports: clk, rst, start, a, b, busy, done, product[2N−1:0].
  - Internal log2N+1-bit counter.
- Top level contains:
  - Combinational single-cycle datapath (N+1-bit add/sub for carry).
  - Handshake control and FSM.
  - Result/flag registers.

## Test plan (N=8)
- ADD a=0x7F, b=0x01 → one cycle after accept: out=0x80, overflow=1, carry=0, negative=1, zero=0.
- SUB a=0x05, b=0x05 → out=0x00, zero=1, carry=0. Then SUB a=0x03, b=0x05 → out=0xFE, carry=1, negative=1, overflow=0.
- MUL a=0xFF, b=0xFF → out_hi=0xFE, out=0x01, overflow=1. out_valid rises exactly 8 edges after the accept edge; in_ready=0 in every MUL cycle.
- Backpressure: ADD accepted with out_ready=0, then AND held with in_valid=1 → in_ready=0 and out stable for 5 cycles. Raise out_ready → AND accepted on that edge; out_valid remains 1 with the AND result next cycle.
- SHL a=0x81, b=0x01 → out=0x02, carry=1. SLT a=0x80, b=0x01 → out=0x01. SHL with b=0x08 (shift amount 0) → out=a, carry=0.
- Assert rst for 1 cycle during the 4th MUL iteration → out_valid stays 0; all outputs 0; in_ready=1 the cycle after reset deasserts. A following ADD 0x02+0x03 gives out=0x05.
